// File: rtl/tmds_clk_pkg.sv
// Shared definitions for the TMDS clocking blocks.
// Contents: the PLL supervisor state enum, the reset-control payload and its
// per-state decode, and constant helpers that size shared cycle counters.
package tmds_clk_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    SER_REL   = 3'd3,
    RUN       = 3'd4
  } sup_state_e;

  // Reset-control outputs driven by the supervisor.
  typedef struct packed {
    logic pll_rst;
    logic ser_rst;
    logic pix_rst_n;
    logic ready;
  } rst_ctl_t;

  // Output levels owned by each state. Reset release is ordered PLL, serializer, pixel.
  function automatic rst_ctl_t rst_decode(input sup_state_e st);
    rst_ctl_t c;
    c = '{pll_rst: 1'b1, ser_rst: 1'b1, pix_rst_n: 1'b0, ready: 1'b0};
    case (st)
      WAIT_LOCK, STABLE: c.pll_rst = 1'b0;
      SER_REL: begin
        c.pll_rst = 1'b0;
        c.ser_rst = 1'b0;
      end
      RUN: begin
        c.pll_rst   = 1'b0;
        c.ser_rst   = 1'b0;
        c.pix_rst_n = 1'b1;
        c.ready     = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..max_val-1 (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'(1) << w) < 64'(max_val))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic asynchronous-to-clk single-bit synchronizer.
// Ports: clk, rst_n (async active-low, chain resets to 0), d (async input),
// q (synchronized output, STAGES flops after d).
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift register; chain[0] is the metastability-catching flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tmds_pll_supervisor.sv
// Lock/reset supervisor for the TMDS PLL, running on the free-running board clock.
// Drives PLL RESET, filters the asynchronous PLL lock, then releases the serializer
// reset and afterwards the pixel reset. Restarts on lock loss or soft reset.
// Ports:
//   clk, rst_n      board clock, async active-low reset
//   pll_lock        PLL LOCK (asynchronous to clk)
//   soft_rst        one-cycle synchronous restart request
//   pll_rst         PLL RESET, active high
//   ser_rst         serializer reset, active high
//   pix_rst_n       pixel-domain reset, active low
//   ready           high only while running
//   retry_cnt       saturating count of lock timeouts
//   loss_cnt        saturating count of lock losses after lock was qualified
module tmds_pll_supervisor
  import tmds_clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned SER_TO_PIX     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       ser_rst,
  output logic       pix_rst_n,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned CNT_MAX = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                          max_u(STABLE_CYCLES, SER_TO_PIX));
  localparam int unsigned CW      = cnt_width(CNT_MAX);

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SER_LAST     = CW'(SER_TO_PIX - 1);
  localparam rst_ctl_t      CTL_RESET    = rst_decode(RST_PLL);

  sup_state_e    state;
  sup_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          lock_s;
  logic          retry_inc;
  logic          loss_inc;
  rst_ctl_t      ctl_q;

  // Lock synchronizer; the FSM never looks at raw pll_lock.
  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // Next-state logic; soft_rst overrides every state.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (soft_rst) begin
      state_nxt = RST_PLL;
    end else begin
      case (state)
        RST_PLL: begin
          if (cnt == PLL_RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Lock wins over a coincident timeout.
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = RST_PLL;
            retry_inc = 1'b1;
          end
        end
        STABLE: begin
          // A dropout here is a glitch, not a loss: just re-wait with a fresh timeout.
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = SER_REL;
          end
        end
        SER_REL: begin
          if (!lock_s) begin
            state_nxt = RST_PLL;
            loss_inc  = 1'b1;
          end else if (cnt == SER_LAST) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt = RST_PLL;
            loss_inc  = 1'b1;
          end
        end
        default: state_nxt = RST_PLL;
      endcase
    end
  end

  // Shared counter restarts on any state change or restart request; idle in RUN.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (soft_rst || (state_nxt != state)) begin
      cnt_nxt = '0;
    end else if (state == RUN) begin
      cnt_nxt = cnt;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_PLL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= CTL_RESET;
    end else begin
      ctl_q <= rst_decode(state_nxt);
    end
  end

  // Saturating event counters; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= 8'd0;
      loss_cnt  <= 8'd0;
    end else begin
      if (retry_inc && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
      if (loss_inc && (loss_cnt != 8'hFF))   loss_cnt  <= loss_cnt + 8'd1;
    end
  end

  assign pll_rst   = ctl_q.pll_rst;
  assign ser_rst   = ctl_q.ser_rst;
  assign pix_rst_n = ctl_q.pix_rst_n;
  assign ready     = ctl_q.ready;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Self-checking bench for tmds_pll_supervisor with small timing parameters.
// Expected outputs are listed per clock edge (edge 1 = first edge after rst_n release),
// queued as stimulus is planned and compared on the falling edge when that edge arrives.
module tb_tmds_pll_supervisor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst;
  logic       ser_rst;
  logic       pix_rst_n;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    string name;
    int    edge_n;
    logic  pll;
    logic  ser;
    logic  pixn;
    logic  rdy;
    int    retry;
    int    loss;
  } vec_t;

  vec_t sb[$];
  vec_t cur;

  always #5 clk = ~clk;

  tmds_pll_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .SER_TO_PIX    (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .soft_rst (soft_rst),
    .pll_rst  (pll_rst),
    .ser_rst  (ser_rst),
    .pix_rst_n(pix_rst_n),
    .ready    (ready),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t v(input string n, input int e, input logic p, input logic s,
                             input logic x, input logic r, input int rt, input int ls);
    vec_t t;
    t.name = n; t.edge_n = e; t.pll = p; t.ser = s; t.pixn = x; t.rdy = r;
    t.retry = rt; t.loss = ls;
    return t;
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && (sb.size() > 0) && (sb[0].edge_n <= cyc)) begin
      cur = sb.pop_front();
      chk({cur.name, ".edge"},      32'(cyc),       32'(cur.edge_n));
      chk({cur.name, ".pll_rst"},   32'(pll_rst),   32'(cur.pll));
      chk({cur.name, ".ser_rst"},   32'(ser_rst),   32'(cur.ser));
      chk({cur.name, ".pix_rst_n"}, 32'(pix_rst_n), 32'(cur.pixn));
      chk({cur.name, ".ready"},     32'(ready),     32'(cur.rdy));
      chk({cur.name, ".retry_cnt"}, 32'(retry_cnt), 32'(cur.retry));
      chk({cur.name, ".loss_cnt"},  32'(loss_cnt),  32'(cur.loss));
    end
  end

  // Ordering invariants, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_pix_while_ser", 32'(pix_rst_n & ser_rst), 32'(0));
      chk("inv_ser_while_pll", 32'(~ser_rst & pll_rst), 32'(0));
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".pll_rst"},   32'(pll_rst),   32'(1));
    chk({nm, ".ser_rst"},   32'(ser_rst),   32'(1));
    chk({nm, ".pix_rst_n"}, 32'(pix_rst_n), 32'(0));
    chk({nm, ".ready"},     32'(ready),     32'(0));
    chk({nm, ".retry_cnt"}, 32'(retry_cnt), 32'(0));
    chk({nm, ".loss_cnt"},  32'(loss_cnt),  32'(0));
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while ((cyc < n) && (guard < 20000)) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) chk("wait_bound", 32'(cyc), 32'(n));
  endtask

  task automatic do_reset(input string nm);
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset_vals(nm);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string nm, input int last);
    wait_cyc(last);
    @(negedge clk);
    chk({nm, ".drained"}, 32'(sb.size()), 32'(0));
  endtask

  // Lock captured by the synchronizer at edge 10: lock_s high after edge 11, the FSM
  // sees it at edge 12 (STABLE), 8 STABLE cycles -> SER_REL at 20, 3 more -> RUN at 23.
  task automatic push_clean_seq(input string nm);
    vec_t t1[6];
    t1 = '{v({nm, "_rst3"},   3, 1, 1, 0, 0, 0, 0),
           v({nm, "_wait4"},  4, 0, 1, 0, 0, 0, 0),
           v({nm, "_stab19"}, 19, 0, 1, 0, 0, 0, 0),
           v({nm, "_ser20"},  20, 0, 0, 0, 0, 0, 0),
           v({nm, "_ser22"},  22, 0, 0, 0, 0, 0, 0),
           v({nm, "_run23"},  23, 0, 0, 1, 1, 0, 0)};
    for (int i = 0; i < 6; i++) sb.push_back(t1[i]);
  endtask

  initial begin
    vec_t t4[16];
    vec_t t3[5];
    vec_t t2[9];

    // Tests 1, 4, 5 in one run: clean lock, one-cycle dropout in RUN, soft resets.
    do_reset("t1_reset");
    push_clean_seq("t1");
    t4 = '{v("t4_run31",    31, 0, 0, 1, 1, 0, 0),
           v("t4_loss32",   32, 1, 1, 0, 0, 0, 1),
           v("t4_rst35",    35, 1, 1, 0, 0, 0, 1),
           v("t4_wait36",   36, 0, 1, 0, 0, 0, 1),
           v("t4_stab44",   44, 0, 1, 0, 0, 0, 1),
           v("t4_ser45",    45, 0, 0, 0, 0, 0, 1),
           v("t4_ser47",    47, 0, 0, 0, 0, 0, 1),
           v("t4_run48",    48, 0, 0, 1, 1, 0, 1),
           v("t5_run49",    49, 0, 0, 1, 1, 0, 1),
           v("t5_softrun",  50, 1, 1, 0, 0, 0, 1),
           v("t5_stab57",   57, 0, 1, 0, 0, 0, 1),
           v("t5_softstab", 58, 1, 1, 0, 0, 0, 1),
           v("t5_ser73",    73, 0, 0, 0, 0, 0, 1),
           v("t5_softentry",74, 1, 1, 0, 0, 0, 1),
           v("t5_ser89",    89, 0, 0, 0, 0, 0, 1),
           v("t5_run90",    90, 0, 0, 1, 1, 0, 1)};
    for (int i = 0; i < 16; i++) sb.push_back(t4[i]);
    wait_cyc(9);  pll_lock = 1'b1;
    wait_cyc(29); pll_lock = 1'b0;
    wait_cyc(30); pll_lock = 1'b1;
    wait_cyc(49); soft_rst = 1'b1;
    wait_cyc(50); soft_rst = 1'b0;
    wait_cyc(57); soft_rst = 1'b1;
    wait_cyc(58); soft_rst = 1'b0;
    wait_cyc(73); soft_rst = 1'b1;   // seen on the edge that would enter RUN
    wait_cyc(74); soft_rst = 1'b0;
    drain("t1_t4_t5", 90);

    // Test 3: 5-cycle lock pulse, then steady lock.
    do_reset("t3_reset");
    t3 = '{v("t3_stab16", 16, 0, 1, 0, 0, 0, 0),
           v("t3_wait17", 17, 0, 1, 0, 0, 0, 0),
           v("t3_stab29", 29, 0, 1, 0, 0, 0, 0),
           v("t3_ser30",  30, 0, 0, 0, 0, 0, 0),
           v("t3_run33",  33, 0, 0, 1, 1, 0, 0)};
    for (int i = 0; i < 5; i++) sb.push_back(t3[i]);
    wait_cyc(9);  pll_lock = 1'b1;
    wait_cyc(14); pll_lock = 1'b0;
    wait_cyc(19); pll_lock = 1'b1;
    drain("t3", 33);

    // Test 2: no lock. Period is 4 + 20 = 24 edges; retry_cnt = k at edge 24k, capped.
    do_reset("t2_reset");
    t2 = '{v("t2_wait23", 23, 0, 1, 0, 0, 0, 0),
           v("t2_to1",    24, 1, 1, 0, 0, 1, 0),
           v("t2_rst27",  27, 1, 1, 0, 0, 1, 0),
           v("t2_wait28", 28, 0, 1, 0, 0, 1, 0),
           v("t2_wait47", 47, 0, 1, 0, 0, 1, 0),
           v("t2_to2",    48, 1, 1, 0, 0, 2, 0),
           v("t2_to254",  6096, 1, 1, 0, 0, 254, 0),
           v("t2_to255",  6120, 1, 1, 0, 0, 255, 0),
           v("t2_to300",  7200, 1, 1, 0, 0, 255, 0)};
    for (int i = 0; i < 9; i++) sb.push_back(t2[i]);
    drain("t2", 7200);

    // Test 6: async reset in SER_REL, then a clean sequence.
    do_reset("t6_reset");
    sb.push_back(v("t6_ser20", 20, 0, 0, 0, 0, 0, 0));
    sb.push_back(v("t6_ser21", 21, 0, 0, 0, 0, 0, 0));
    wait_cyc(9); pll_lock = 1'b1;
    wait_cyc(21);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    chk("t6_pre.drained", 32'(sb.size()), 32'(0));
    do_reset("t6_hold");
    push_clean_seq("t6");
    wait_cyc(9); pll_lock = 1'b1;
    drain("t6", 23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

endmodule
